// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding, bit-timing helper and count width for the ROM loader UART
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_t;

  localparam int BYTE_COUNT_W = 22;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rom_rx_if.sv
// rtl/uart_rom_rx_if.sv - received-byte strobe bundle from the UART to the game loader
interface uart_rom_rx_if;
  logic [7:0] data;
  logic       data_clk;

  modport master (output data, output data_clk);
  modport slave  (input  data, input  data_clk);
endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - STAGES-deep synchroniser; resets to 1 so an idle line never looks like a start bit
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!reset_n) r_sync <= '1;
    else          r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rom_rx.sv
// rtl/uart_rom_rx.sv - UART byte receiver feeding the iNES loader (8N1; 8E1 when UART_RX_PARITY_EN is defined)
module uart_rom_rx
  import loader_pkg::*;
#(
  parameter int CLK_HZ      = 27_000_000,
  parameter int BAUD        = 115_200,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_uart_rx,
  uart_rom_rx_if.master           o_rx_byte,
  output logic                    o_busy,
  output logic                    o_frame_err,
  output logic                    o_parity_err,
  output logic [BYTE_COUNT_W-1:0] o_byte_count
);

  localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
  localparam int CTR_W = $clog2(CPB);
  localparam logic [CTR_W-1:0] HALF = CTR_W'(CPB / 2 - 1);
  localparam logic [CTR_W-1:0] LAST = CTR_W'(CPB - 1);
`ifdef UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = PARITY;
`else
  localparam rx_state_t AFTER_DATA = STOP;
`endif

  rx_state_t               r_state, w_next;
  logic                    w_rx_s, w_sample, w_frame_good;
  logic [CTR_W-1:0]        r_bit_ctr;
  logic [2:0]              r_bit_idx;
  logic [7:0]              r_shreg, r_data;
  logic                    r_data_clk, r_frame_err;
  logic [BYTE_COUNT_W-1:0] r_byte_count;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (i_uart_rx),
    .o_q     (w_rx_s)
  );

  // START samples at half a bit so every later sample lands mid-bit after a full bit period
  always_comb begin
    w_next   = r_state;
    w_sample = 1'b0;
    case (r_state)
      IDLE:      if (!w_rx_s) w_next = START;
      START:     if (r_bit_ctr == HALF) begin
                   w_sample = 1'b1;
                   w_next   = w_rx_s ? IDLE : DATA;
                 end
      DATA:      if (r_bit_ctr == LAST) begin
                   w_sample = 1'b1;
                   if (r_bit_idx == 3'd7) w_next = AFTER_DATA;
                 end
`ifdef UART_RX_PARITY_EN
      PARITY:    if (r_bit_ctr == LAST) begin
                   w_sample = 1'b1;
                   w_next   = STOP;
                 end
`endif
      STOP:      if (r_bit_ctr == LAST) begin
                   w_sample = 1'b1;
                   w_next   = w_rx_s ? IDLE : WAIT_IDLE;
                 end
      WAIT_IDLE: if (w_rx_s) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_bit_ctr    <= '0;
      r_bit_idx    <= '0;
      r_shreg      <= '0;
      r_data       <= '0;
      r_data_clk   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_byte_count <= '0;
    end else begin
      r_state    <= w_next;
      r_data_clk <= 1'b0;
      if (r_state == IDLE || r_state == WAIT_IDLE || w_sample) r_bit_ctr <= '0;
      else                                                      r_bit_ctr <= r_bit_ctr + 1'b1;
      if (r_state == START) r_bit_idx <= '0;
      if (r_state == DATA && w_sample) begin
        r_shreg   <= {w_rx_s, r_shreg[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (r_state == STOP && w_sample) begin
        if (!w_rx_s) begin
          r_frame_err <= 1'b1;
        end else if (w_frame_good) begin
          r_data     <= r_shreg;
          r_data_clk <= 1'b1;
          if (r_byte_count != '1) r_byte_count <= r_byte_count + 1'b1;
        end
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad, r_parity_err;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else if (r_state == START) begin
      r_par_bad <= 1'b0;
    end else if (r_state == PARITY && w_sample && (w_rx_s != ^r_shreg)) begin
      r_par_bad    <= 1'b1;
      r_parity_err <= 1'b1;
    end
  end

  assign w_frame_good = !r_par_bad;
  assign o_parity_err = r_parity_err;
`else
  assign w_frame_good = 1'b1;
  assign o_parity_err = 1'b0;
`endif

  assign o_rx_byte.data     = r_data;
  assign o_rx_byte.data_clk = r_data_clk;
  assign o_busy             = (r_state != IDLE);
  assign o_frame_err        = r_frame_err;
  assign o_byte_count       = r_byte_count;

endmodule

// File: tb/tb_uart_rom_rx.sv
// tb/tb_uart_rom_rx.sv - self-checking bench for uart_rom_rx (16 clks/bit, optional UART_RX_PARITY_EN)
module tb_uart_rom_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 171;
`else
  localparam int LAT = 155;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        busy, ferr, perr;
  logic [21:0] cnt;

  uart_rom_rx_if out_if ();

  uart_rom_rx #(.CLK_HZ(1_600_000), .BAUD(100_000), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_uart_rx    (uart_rx),
    .o_rx_byte    (out_if),
    .o_busy       (busy),
    .o_frame_err  (ferr),
    .o_parity_err (perr),
    .o_byte_count (cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] got_q[$];
  int         got_t[$];
  always @(negedge clk) begin
    if (out_if.data_clk === 1'b1) begin
      got_q.push_back(out_if.data);
      got_t.push_back(cyc);
    end
  end

  logic [7:0] exp_q[$];
  int         exp_cnt;
  logic       exp_ferr, exp_perr;
  int         n_cmp = 0;
  int         n_bad = 0;

  // Reference: a frame yields a byte only with a high stop bit and (if used) correct parity
  task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
`ifdef UART_RX_PARITY_EN
    if (!par_ok) exp_perr = 1'b1;
`else
    par_ok = 1'b1;
`endif
    if (!stop_ok) exp_ferr = 1'b1;
    else if (par_ok) begin
      exp_q.push_back(b);
      if (exp_cnt < 22'h3FFFFF) exp_cnt++;
    end
  endtask

  task automatic send_bit(input logic v);
    uart_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^b) ^ !par_ok);
`endif
    send_bit(stop_ok);
    model_frame(b, stop_ok, par_ok);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({busy, ferr, perr, out_if.data_clk} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b expected 0000", {busy, ferr, perr, out_if.data_clk}); end
    n_cmp++; if ({out_if.data, cnt} !== 30'h0) begin n_bad++; $display("FAIL reset_data_count: got %h/%h expected 0/0", out_if.data, cnt); end
    reset_n = 1'b1;
    exp_cnt = 0; exp_ferr = 1'b0; exp_perr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] fixed[4];
    int ts[4];
    int n;
    fixed = '{8'h4E, 8'h45, 8'h53, 8'h1A};
    got_q.delete(); got_t.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      ts[i] = cyc;
      send_frame(fixed[i], 1'b1, 1'b1);
    end
    n_cmp++; if (got_q.size() !== 4) begin n_bad++; $display("FAIL b2b_strobes: got %0d expected 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== fixed[i]) begin n_bad++; $display("FAIL b2b_data%0d: got %h expected %h", i, got_q[i], fixed[i]); end
      n_cmp++; if (got_t[i] !== ts[i] + LAT) begin n_bad++; $display("FAIL b2b_latency%0d: got %0d expected %0d", i, got_t[i] - ts[i], LAT); end
    end
    n_cmp++; if (cnt !== 22'd4) begin n_bad++; $display("FAIL b2b_count: got %0d expected 4", cnt); end
    n_cmp++; if ({ferr, perr} !== 2'b00) begin n_bad++; $display("FAIL b2b_errors: got %b expected 00", {ferr, perr}); end
    // Random bytes with random idle gaps, including zero
    for (int i = 0; i < 8; i++) begin
      send_frame(8'($urandom), 1'b1, 1'b1);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    n = exp_q.size();
    n_cmp++; if (got_q.size() !== n) begin n_bad++; $display("FAIL rand_strobes: got %0d expected %0d", got_q.size(), n); end
    for (int i = 4; i < n && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_data%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (cnt !== 22'(exp_cnt)) begin n_bad++; $display("FAIL rand_count: got %0d expected %0d", cnt, exp_cnt); end
  endtask

  task automatic test_glitch();
    got_q.delete();
    uart_rx = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_start: got %b expected 1", busy); end
    uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_end: got %b expected 0", busy); end
    n_cmp++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL glitch_strobes: got %0d expected 0", got_q.size()); end
    n_cmp++; if ({ferr, perr} !== {exp_ferr, exp_perr}) begin n_bad++; $display("FAIL glitch_errors: got %b expected %b", {ferr, perr}, {exp_ferr, exp_perr}); end
  endtask

  task automatic test_frame_err();
    got_q.delete(); exp_q.delete();
    send_frame(8'hA5, 1'b0, 1'b1);
    uart_rx = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    n_cmp++; if ({busy, ferr} !== 2'b11) begin n_bad++; $display("FAIL ferr_hold: got busy,ferr=%b expected 11", {busy, ferr}); end
    n_cmp++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL ferr_no_strobe: got %0d expected 0", got_q.size()); end
    send_bit(1'b1);
    send_frame(8'h3C, 1'b1, 1'b1);
    n_cmp++; if (got_q.size() !== 1 || got_q[0] !== 8'h3C) begin n_bad++; $display("FAIL ferr_recover: got %0d strobes first %h expected 1 of 3c", got_q.size(), got_q.size() ? got_q[0] : 8'h0); end
    n_cmp++; if (ferr !== exp_ferr || cnt !== 22'(exp_cnt)) begin n_bad++; $display("FAIL ferr_sticky: got %b/%0d expected %b/%0d", ferr, cnt, exp_ferr, exp_cnt); end
  endtask

  task automatic test_mid_reset();
    got_q.delete(); exp_q.delete();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (CPB / 2) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mreset_busy: got %b expected 1", busy); end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_cnt = 0; exp_ferr = 1'b0; exp_perr = 1'b0;
    n_cmp++; if ({busy, ferr, perr, out_if.data_clk, out_if.data, cnt} !== 34'h0) begin n_bad++; $display("FAIL mreset_outputs: got %b %h %h expected all 0", {busy, ferr, perr, out_if.data_clk}, out_if.data, cnt); end
    repeat (5 * CPB) @(negedge clk);
    send_frame(8'h81, 1'b1, 1'b1);
    n_cmp++; if (got_q.size() !== 1 || got_q[0] !== 8'h81) begin n_bad++; $display("FAIL mreset_next: got %0d strobes first %h expected 1 of 81", got_q.size(), got_q.size() ? got_q[0] : 8'h0); end
    n_cmp++; if (cnt !== 22'd1) begin n_bad++; $display("FAIL mreset_count: got %0d expected 1", cnt); end
  endtask

  task automatic test_parity();
    got_q.delete(); exp_q.delete();
    send_frame(8'h07, 1'b1, 1'b1);
    n_cmp++; if (got_q.size() !== 1 || got_q[0] !== 8'h07) begin n_bad++; $display("FAIL par_good: got %0d strobes first %h expected 1 of 07", got_q.size(), got_q.size() ? got_q[0] : 8'h0); end
    n_cmp++; if (perr !== 1'b0) begin n_bad++; $display("FAIL par_good_err: got %b expected 0", perr); end
`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    n_cmp++; if (got_q.size() !== 1) begin n_bad++; $display("FAIL par_bad_strobe: got %0d expected 1", got_q.size()); end
    n_cmp++; if (perr !== 1'b1) begin n_bad++; $display("FAIL par_bad_err: got %b expected 1", perr); end
`endif
    n_cmp++; if (cnt !== 22'(exp_cnt)) begin n_bad++; $display("FAIL par_count: got %0d expected %0d", cnt, exp_cnt); end
  endtask

  task automatic test_saturate();
    got_q.delete(); exp_q.delete();
    force dut.r_byte_count = 22'h3FFFFE;
    @(negedge clk);
    release dut.r_byte_count;
    exp_cnt = 22'h3FFFFE;
    @(negedge clk);
    n_cmp++; if (cnt !== 22'h3FFFFE) begin n_bad++; $display("FAIL sat_preload: got %h expected 3ffffe", cnt); end
    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1, 1'b1);
    n_cmp++; if (got_q.size() !== 3) begin n_bad++; $display("FAIL sat_strobes: got %0d expected 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL sat_data%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (cnt !== 22'(exp_cnt)) begin n_bad++; $display("FAIL sat_count: got %h expected %h", cnt, exp_cnt); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_mid_reset();
    test_parity();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
